// File: rtl/alu_share_arb_pkg.sv
// Shared op codes, FSM encodings and grant helper for the shared-ALU arbiter.
package alu_share_arb_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_LOR  = 3'b010,
        OP_LAND = 3'b011,
        OP_Z0   = 3'b100,
        OP_Z1   = 3'b101,
        OP_MIX0 = 3'b110,
        OP_MIX1 = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } arb_state_e;

    // Round-robin pick: a lone requester wins, on contention the one not served last wins.
    function automatic logic pick_grant(input logic v0, input logic v1, input logic last);
        if (v0 && v1) begin
            return ~last;
        end
        return v1;
    endfunction

endpackage

// File: rtl/alu_share_arb_alu_core.sv
// Combinational 8-bit ALU shared by both requesters; 1-bit results are zero-extended.
module alu_core
    import alu_share_arb_pkg::*;
#(
    parameter int W = 8
) (
    output logic [W-1:0] z,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [2:0]   sel
);

    logic flag;

    always_comb begin
        z    = '0;
        flag = 1'b0;
        case (alu_op_e'(sel))
            OP_ADD:  z = a + b;
            OP_SUB:  z = a - b;
            OP_LOR:  flag = (a != '0) || (b != '0);
            OP_LAND: flag = (a != '0) && (b != '0);
            OP_Z0:   flag = 1'b0;
            OP_Z1:   flag = 1'b0;
            OP_MIX0: flag = (a[2:0] != 3'b000) && a[W-1];
            OP_MIX1: flag = a[0] && (a[W-1:1] != '0);
            default: flag = 1'b0;
        endcase
        if (sel[2] || sel[1]) begin
            z = {{(W-1){1'b0}}, flag};
        end
    end

endmodule

// File: rtl/alu_share_arb.sv
// Round-robin arbiter/sequencer for two requesters sharing one combinational ALU.
// state  | meaning
// S_IDLE | arbitrate, accept one request and latch its operands
// S_EXEC | ALU evaluates latched operands, result registered to granted rsp port
// S_RESP | hold result until the granted requester takes it
module alu_share_arb
    import alu_share_arb_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic [2:0]   req0_sel,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    input  logic [2:0]   req1_sel,
    output logic         rsp0_valid,
    input  logic         rsp0_ready,
    output logic [W-1:0] rsp0_data,
    output logic         rsp0_zero,
    output logic         rsp1_valid,
    input  logic         rsp1_ready,
    output logic [W-1:0] rsp1_data,
    output logic         rsp1_zero,
    output logic         busy,
    output logic         last_gnt
);

    arb_state_e   state_q, state_d;
    logic         gnt_q, gnt_d;
    logic         last_gnt_q, last_gnt_d;
    logic [W-1:0] a_q, a_d, b_q, b_d;
    logic [2:0]   sel_q, sel_d;
    logic [1:0]   rsp_valid_q, rsp_valid_d;
    logic [1:0]   rsp_zero_q, rsp_zero_d;
    logic [W-1:0] rsp0_data_q, rsp0_data_d, rsp1_data_q, rsp1_data_d;
    logic [W-1:0] alu_z;
    logic         grant;
    logic         taken;

    alu_core #(.W(W)) u_alu (
        .z   (alu_z),
        .a   (a_q),
        .b   (b_q),
        .sel (sel_q)
    );

    assign grant = pick_grant(req0_valid, req1_valid, last_gnt_q);
    assign taken = gnt_q ? rsp1_ready : rsp0_ready;

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        last_gnt_d  = last_gnt_q;
        a_d         = a_q;
        b_d         = b_q;
        sel_d       = sel_q;
        rsp_valid_d = rsp_valid_q;
        rsp_zero_d  = rsp_zero_q;
        rsp0_data_d = rsp0_data_q;
        rsp1_data_d = rsp1_data_q;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req0_valid || req1_valid) begin
                    gnt_d      = grant;
                    a_d        = grant ? req1_a   : req0_a;
                    b_d        = grant ? req1_b   : req0_b;
                    sel_d      = grant ? req1_sel : req0_sel;
                    req0_ready = ~grant;
                    req1_ready = grant;
                    state_d    = S_EXEC;
                end
            end
            S_EXEC: begin
                if (gnt_q) begin
                    rsp1_data_d = alu_z;
                end else begin
                    rsp0_data_d = alu_z;
                end
                rsp_zero_d[gnt_q]  = (alu_z == '0);
                rsp_valid_d[gnt_q] = 1'b1;
                last_gnt_d         = gnt_q;
                state_d            = S_RESP;
            end
            S_RESP: begin
                if (taken) begin
                    rsp_valid_d[gnt_q] = 1'b0;
                    state_d            = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Reset drops any in-flight operation without issuing a response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            gnt_q       <= 1'b0;
            last_gnt_q  <= 1'b1;
            a_q         <= '0;
            b_q         <= '0;
            sel_q       <= '0;
            rsp_valid_q <= '0;
            rsp_zero_q  <= '0;
            rsp0_data_q <= '0;
            rsp1_data_q <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            last_gnt_q  <= last_gnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sel_q       <= sel_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_zero_q  <= rsp_zero_d;
            rsp0_data_q <= rsp0_data_d;
            rsp1_data_q <= rsp1_data_d;
        end
    end

    assign rsp0_valid = rsp_valid_q[0];
    assign rsp1_valid = rsp_valid_q[1];
    assign rsp0_zero  = rsp_zero_q[0];
    assign rsp1_zero  = rsp_zero_q[1];
    assign rsp0_data  = rsp0_data_q;
    assign rsp1_data  = rsp1_data_q;
    assign busy       = (state_q != S_IDLE);
    assign last_gnt   = last_gnt_q;

endmodule
